// File: rtl/tlut_pkg.sv
// Shared defaults and FSM state encoding for the table-LUT SIMD sequencer.
package tlut_pkg;

    localparam int DIM_A_DEF        = 9;
    localparam int DIM_C_DEF        = 9;
    localparam int DIM_MULT_DEF     = 9;
    localparam int INPUT_WIDTH_DEF  = 4;
    localparam int WEIGHT_WIDTH_DEF = 4;
    localparam int ACC_WIDTH_DEF    = 8;
    localparam int DRAIN_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_HOLD
    } tlut_state_e;

    // Counter width able to hold the larger of the two phase lengths.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/tlut_cycle_counter.sv
// Up-counter with synchronous load-to-zero and a terminal-count flag.
module tlut_cycle_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign count = cnt_q;
    assign tc    = (cnt_q == term);

endmodule

// File: rtl/tlut_seq_ctrl.sv
// Job sequencer for a simd_cell: clear, run for RUN_CYCLES, drain, then hold
// the captured products until the consumer takes them.
module tlut_seq_ctrl
    import tlut_pkg::*;
#(
    parameter int DIM_A        = DIM_A_DEF,
    parameter int DIM_C        = DIM_C_DEF,
    parameter int DIM_MULT     = DIM_MULT_DEF,
    parameter int INPUT_WIDTH  = INPUT_WIDTH_DEF,
    parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
    parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
    parameter int RUN_CYCLES   = 2**INPUT_WIDTH,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DIM_A-1:0][INPUT_WIDTH-1:0]      in_act,
    input  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]     in_wgt,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DIM_MULT-1:0][ACC_WIDTH-1:0]     out_prod,
    output logic                                   cell_rst_n,
    output logic                                   cell_enable,
    output logic [DIM_A-1:0][INPUT_WIDTH-1:0]      cell_input_bin,
    output logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]     cell_weight_bin,
    input  logic [DIM_MULT-1:0][ACC_WIDTH-1:0]     cell_product,
    output logic                                   busy,
    output logic [15:0]                            job_count
);

    localparam int CW = cnt_width(RUN_CYCLES, DRAIN_CYCLES);
    localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    tlut_state_e                            state_q, state_d;
    logic [DIM_A-1:0][INPUT_WIDTH-1:0]      act_q, act_d;
    logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]     wgt_q, wgt_d;
    logic [DIM_MULT-1:0][ACC_WIDTH-1:0]     prod_q, prod_d;
    logic [15:0]                            job_count_q, job_count_d;

    logic          cnt_load, cnt_en, cnt_tc;
    logic [CW-1:0] cnt_term, cnt_val;

    // One counter times both phases; it is re-zeroed on each phase entry.
    tlut_cycle_counter #(.W(CW)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .en    (cnt_en),
        .term  (cnt_term),
        .count (cnt_val),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        wgt_d       = wgt_q;
        prod_d      = prod_q;
        job_count_d = job_count_q;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_term    = RUN_LAST;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    act_d    = in_act;
                    wgt_d    = in_wgt;
                    cnt_load = 1'b1;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: begin
                if (cnt_tc) begin
                    cnt_load = 1'b1;
                    state_d  = ST_DRAIN;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                cnt_term = DRAIN_LAST;
                if (cnt_tc) begin
                    prod_d  = cell_product;
                    state_d = ST_HOLD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    job_count_d = job_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            act_q       <= '0;
            wgt_q       <= '0;
            prod_q      <= '0;
            job_count_q <= '0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            wgt_q       <= wgt_d;
            prod_q      <= prod_d;
            job_count_q <= job_count_d;
        end
    end

    assign in_ready        = (state_q == ST_IDLE);
    assign out_valid       = (state_q == ST_HOLD);
    assign busy            = (state_q != ST_IDLE);
    assign cell_enable     = (state_q == ST_RUN);
    // Cell is held in clear during our own reset as well as the CLEAR beat.
    assign cell_rst_n      = ~rst & (state_q != ST_CLEAR);
    assign cell_input_bin  = act_q;
    assign cell_weight_bin = wgt_q;
    assign out_prod        = prod_q;
    assign job_count       = job_count_q;

endmodule
